// File: rtl/zx_cmd_handshake.sv
// rtl/zx_cmd_handshake.sv - four-phase req/ack bridge between the ZX command port and the SD loader PIO
module zx_cmd_handshake #(
  parameter int CMD_W       = 8,
  parameter int TIMEOUT_W   = 20,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             host_wr,
  input  logic [CMD_W-1:0] host_cmd,
  input  logic             host_clr,
  output logic             cmd_req,
  output logic [CMD_W-1:0] cmd_code,
  input  logic             cmd_ack,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic             overrun
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DRAIN = 3'd1,
    S_REQ   = 3'd2,
    S_REL   = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  // The phase expires on the cycle its count would reach all-ones.
  localparam logic [TIMEOUT_W-1:0] TMO_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
  localparam logic [TIMEOUT_W-1:0] TMO_MAX  = {TIMEOUT_W{1'b1}};

  state_t                 state, state_nx;
  logic [SYNC_STAGES-1:0] ack_sync;
  logic                   ack_s;
  logic [TIMEOUT_W-1:0]   tmo_cnt;
  logic                   tmo_hit;
  logic                   clr_ok;
  logic                   req_nx, busy_nx, done_nx, timeout_nx, overrun_nx;
  logic [CMD_W-1:0]       code_nx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ack_sync <= '0;
    else          ack_sync <= {ack_sync[SYNC_STAGES-2:0], cmd_ack};
  end

  assign ack_s   = ack_sync[SYNC_STAGES-1];
  assign tmo_hit = (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      tmo_cnt <= '0;
    end else begin
      state <= state_nx;
      if (state_nx != state)
        tmo_cnt <= '0;
      else if ((state == S_DRAIN || state == S_REQ || state == S_REL) && tmo_cnt != TMO_MAX)
        tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // Handshake progress takes priority over an expiry in the same cycle.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (host_wr) state_nx = ack_s ? S_DRAIN : S_REQ;
      S_DRAIN: if (!ack_s) state_nx = S_REQ; else if (tmo_hit) state_nx = S_ERR;
      S_REQ:   if (ack_s)  state_nx = S_REL; else if (tmo_hit) state_nx = S_ERR;
      S_REL:   if (!ack_s) state_nx = S_IDLE; else if (tmo_hit) state_nx = S_ERR;
      S_ERR:   if (host_clr && !ack_s) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Outputs are computed from the next state so every port comes straight off a flop.
  always_comb begin
    req_nx     = (state_nx == S_REQ);
    busy_nx    = (state_nx != S_IDLE);
    done_nx    = (state == S_REL) && (state_nx == S_IDLE);
    code_nx    = (state == S_IDLE && host_wr) ? host_cmd : cmd_code;
    clr_ok     = host_clr && ((state != S_ERR) || (state_nx == S_IDLE));
    timeout_nx = timeout;
    overrun_nx = overrun;
    if (clr_ok) begin
      timeout_nx = 1'b0;
      overrun_nx = 1'b0;
    end
    if (state_nx == S_ERR && state != S_ERR) timeout_nx = 1'b1;
    if (host_wr && state != S_IDLE)          overrun_nx = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_req  <= 1'b0;
      cmd_code <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      timeout  <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      cmd_req  <= req_nx;
      cmd_code <= code_nx;
      busy     <= busy_nx;
      done     <= done_nx;
      timeout  <= timeout_nx;
      overrun  <= overrun_nx;
    end
  end

endmodule

// File: tb/tb_zx_cmd_handshake.sv
// tb/tb_zx_cmd_handshake.sv - randomized directed bench for zx_cmd_handshake against timing rules
module tb_zx_cmd_handshake;

  localparam int CW  = 8;
  localparam int TW  = 4;
  localparam int SS  = 2;
  localparam int LAT = SS + 1;
  localparam int TMO = (1 << TW) - 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          host_wr;
  logic [CW-1:0] host_cmd;
  logic          host_clr;
  logic          cmd_req;
  logic [CW-1:0] cmd_code;
  logic          cmd_ack;
  logic          busy, done, timeout, overrun;

  int vectors = 0;
  int miscompares = 0;
  logic exp_ovr, exp_to;

  always #5 clk = ~clk;

  zx_cmd_handshake #(.CMD_W(CW), .TIMEOUT_W(TW), .SYNC_STAGES(SS)) dut (
    .clk(clk), .reset_n(reset_n), .host_wr(host_wr), .host_cmd(host_cmd),
    .host_clr(host_clr), .cmd_req(cmd_req), .cmd_code(cmd_code), .cmd_ack(cmd_ack),
    .busy(busy), .done(done), .timeout(timeout), .overrun(overrun)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkv(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Loader model: ack rises d1 cycles after req is seen, falls d2 cycles after req drops.
  // stale>0 means cmd_ack is already high and is released stale cycles after host_wr.
  // ovr=1 injects a second host_wr during REQ, ovr=2 does so together with host_clr.
  task automatic handshake(input logic [CW-1:0] code, input int d1, input int d2,
                           input int stale, input int ovr);
    host_wr  = 1'b1;
    host_cmd = code;
    tick();
    host_wr  = 1'b0;
    host_clr = 1'b0;
    chk("busy_rise", busy, 1'b1);
    chk("done_width", done, 1'b0);
    chkv("code_latch", 32'(cmd_code), 32'(code));
    if (stale > 0) begin
      chk("drain_req", cmd_req, 1'b0);
      for (int i = 1; i < stale; i++) begin
        tick();
        chk("drain_req", cmd_req, 1'b0);
      end
      cmd_ack = 1'b0;
      for (int i = 1; i <= LAT; i++) begin
        tick();
        chk("drain_exit", cmd_req, i == LAT);
      end
    end else begin
      chk("req_rise", cmd_req, 1'b1);
    end
    for (int i = 1; i < d1; i++) begin
      if (ovr != 0 && i == 1) begin
        host_wr  = 1'b1;
        host_cmd = 8'h11;
        host_clr = (ovr == 2);
        tick();
        host_wr  = 1'b0;
        host_clr = 1'b0;
        exp_ovr  = 1'b1;
        chk("ovr_flag", overrun, 1'b1);
        chkv("ovr_code", 32'(cmd_code), 32'(code));
      end else begin
        tick();
      end
      chk("req_hold", cmd_req, 1'b1);
    end
    cmd_ack = 1'b1;
    for (int i = 1; i <= LAT; i++) begin
      tick();
      chk("req_fall", cmd_req, i != LAT);
      chk("busy_req", busy, 1'b1);
    end
    for (int i = 1; i < d2; i++) begin
      tick();
      chk("rel_busy", busy, 1'b1);
    end
    cmd_ack = 1'b0;
    for (int i = 1; i <= LAT; i++) begin
      tick();
      chk("done_pulse", done, i == LAT);
      chk("busy_fall", busy, i != LAT);
    end
    chkv("code_done", 32'(cmd_code), 32'(code));
    chk("ovr_done", overrun, exp_ovr);
    chk("to_done", timeout, exp_to);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"}, cmd_req, 1'b0);
    chkv({tag, "_code"}, 32'(cmd_code), 32'h0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_to"}, timeout, 1'b0);
    chk({tag, "_ovr"}, overrun, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset_n  = 1'b0;
    host_wr  = 1'b0;
    host_cmd = '0;
    host_clr = 1'b0;
    cmd_ack  = 1'b0;
    exp_ovr  = 1'b0;
    exp_to   = 1'b0;
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Normal command, ack 3 cycles each way.
    handshake(8'h5A, 3, 3, 0, 0);
    tick();
    chk("done_once", done, 1'b0);

    // Stale ack held through the start of the command.
    cmd_ack = 1'b1;
    repeat (3) tick();
    handshake(8'hC3, 2, 2, 10, 0);
    tick();

    // Overrun, then clear in IDLE.
    handshake(8'h3C, 4, 2, 0, 1);
    host_clr = 1'b1;
    tick();
    host_clr = 1'b0;
    exp_ovr  = 1'b0;
    chk("ovr_clear", overrun, 1'b0);

    // Overrun coinciding with host_clr: the set wins.
    handshake(8'h77, 3, 3, 0, 2);
    chk("ovr_set_wins", overrun, 1'b1);

    // host_wr together with host_clr in IDLE: command starts and flags clear.
    exp_ovr  = 1'b0;
    host_clr = 1'b1;
    handshake(8'h9E, 2, 2, 0, 0);

    // Back-to-back: second host_wr lands in the done cycle.
    handshake(8'h01, 1, 1, 0, 0);
    handshake(8'h02, 2, 4, 0, 0);
    tick();

    // Timeout in REQ.
    host_wr  = 1'b1;
    host_cmd = 8'hE1;
    tick();
    host_wr  = 1'b0;
    n = 0;
    while (cmd_req === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    exp_to = 1'b1;
    chkv("tmo_len", 32'(n), 32'(TMO));
    chk("tmo_flag", timeout, 1'b1);
    chk("tmo_busy", busy, 1'b1);
    chk("tmo_req", cmd_req, 1'b0);
    cmd_ack = 1'b1;
    repeat (3) tick();
    host_clr = 1'b1;
    tick();
    host_clr = 1'b0;
    chk("err_hold_busy", busy, 1'b1);
    chk("err_hold_to", timeout, 1'b1);
    cmd_ack = 1'b0;
    repeat (3) tick();
    host_clr = 1'b1;
    tick();
    host_clr = 1'b0;
    exp_to = 1'b0;
    chk("err_exit_busy", busy, 1'b0);
    chk("err_exit_to", timeout, 1'b0);
    tick();

    // Reset in the middle of REL with cmd_ack still high.
    host_wr  = 1'b1;
    host_cmd = 8'hA5;
    tick();
    host_wr  = 1'b0;
    tick();
    cmd_ack = 1'b1;
    repeat (LAT) tick();
    chk("rel_reached", cmd_req, 1'b0);
    host_wr  = 1'b1;
    host_cmd = 8'h22;
    tick();
    host_wr  = 1'b0;
    chk("rel_ovr", overrun, 1'b1);
    reset_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    tick();
    chk("rst_no_done", done, 1'b0);
    reset_n = 1'b1;
    exp_ovr = 1'b0;
    repeat (3) tick();
    handshake(8'h66, 2, 3, $urandom_range(1, 10), 0);

    // Random command stream, some back-to-back.
    for (int k = 0; k < 20; k++) begin
      logic [CW-1:0] code;
      int d1, d2;
      code = CW'($urandom);
      d1   = $urandom_range(1, 5);
      d2   = $urandom_range(1, 5);
      if ($urandom_range(0, 1) == 1) tick();
      handshake(code, d1, d2, 0, 0);
    end
    tick();
    chk("final_idle", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/zx_cmd_handshake.md
# zx_cmd_handshake

Four-phase request/acknowledge bridge between the ZX-side command port and the Nios II SD loader. It latches a command code from the host, drives `cmd_req`/`cmd_code` into the loader's PIO inputs, and waits for the loader's 1-bit `cmd_ack` PIO output to rise and then fall. It reports busy/done/timeout/overrun status back to the host. `cmd_ack` comes from the Nios clock domain, so it is resynchronised here.

## Interface
Parameters:
- `CMD_W`, 8, command code width
- `TIMEOUT_W`, 20, timeout counter width; a phase times out after 2^TIMEOUT_W − 1 cycles
- `SYNC_STAGES`, 2, synchroniser depth on `cmd_ack` (≥2)

Ports:
- `clk`  in  1  block clock
- `reset_n`  in  1  asynchronous, active-low reset
- `host_wr`  in  1  one-cycle strobe: start command
- `host_cmd`  in  CMD_W  command code, sampled on `host_wr`
- `host_clr`  in  1  one-cycle strobe: clear `timeout` and `overrun`
- `cmd_req`  out  1  request to loader PIO
- `cmd_code`  out  CMD_W  latched command, stable while `busy`
- `cmd_ack`  in  1  loader acknowledge, asynchronous
- `busy`  out  1  high in any state except IDLE
- `done`  out  1  one-cycle pulse on successful completion
- `timeout`  out  1  sticky: a phase expired
- `overrun`  out  1  sticky: `host_wr` arrived while not IDLE

## Operation
- `ack_s` is `cmd_ack` after SYNC_STAGES flops. All decisions use `ack_s` only.
- States: IDLE, DRAIN, REQ, REL, ERR.
- IDLE, `host_wr`=1:
  - latch `host_cmd` into `cmd_code`
  - if `ack_s`=1, go to DRAIN; otherwise go to REQ
- DRAIN: `cmd_req`=0. Wait for `ack_s`=0, then go to REQ. Stale ack from an earlier command is flushed here.
- REQ: `cmd_req`=1. `ack_s`=1 → REL.
- REL: `cmd_req`=0. `ack_s`=0 → IDLE and pulse `done`.
- Timeout:
  - counter clears on every state entry and increments each cycle in DRAIN, REQ and REL
  - at all-ones: go to ERR, set `timeout`, drop `cmd_req`
- ERR: `cmd_req`=0, `busy`=1. Leave for IDLE when `host_clr`=1 and `ack_s`=0. `host_clr` while `ack_s`=1 does nothing.
- `host_wr` in any non-IDLE state is ignored (`cmd_code` unchanged) and sets `overrun`.
- `host_clr` outside ERR clears `timeout`/`overrun`. Same cycle as a set: the set wins.
- `host_wr` and `host_clr` together in IDLE: the command starts and the flags clear.
- Reset values: state IDLE, `cmd_req`=0, `cmd_code`=0, `busy`=0, `done`=0, `timeout`=0, `overrun`=0, sync flops 0, counter 0.
- Reset mid-handshake: all outputs return to reset values immediately. No `done`. A still-high `cmd_ack` is handled by DRAIN on the next command.

## Timing
- All outputs are registered.
- `host_wr` in cycle N → `busy`=1 and `cmd_req`=1 (REQ path) at N+1.
- `cmd_ack` rising at input edge M → `ack_s`=1 after SYNC_STAGES edges → `cmd_req`=0 on the following edge.
- `cmd_ack` falling → `done` high for exactly 1 cycle, SYNC_STAGES+1 edges later. `busy` falls in the same cycle `done` rises.
- Minimum command (ack immediate on each edge, SYNC_STAGES=2): 7 cycles from `host_wr` to `done`.
- A new `host_wr` is accepted in the same cycle `done` is high; `busy` is already 0.
- Timeout fires after exactly 2^TIMEOUT_W − 1 cycles in one phase. The counter never wraps.

## Test plan
- Normal, default parameters:
  - `host_wr` with `host_cmd`=0x5A; the model raises `cmd_ack` 3 cycles after `cmd_req` and drops it 3 cycles after `cmd_req` falls
  - required: `cmd_code`=0x5A throughout, one `done` pulse, `busy` back to 0, no flags
- Stale ack:
  - hold `cmd_ack`=1, issue `host_wr`, release `cmd_ack` after 10 cycles
  - required: `cmd_req` stays 0 until 3 cycles after the release, then a normal handshake completes
- Timeout, TIMEOUT_W=4:
  - model never acks
  - required: `cmd_req` high for 15 cycles, then ERR with `timeout`=1, `cmd_req`=0
  - `host_clr` → IDLE, `timeout`=0
- Overrun:
  - second `host_wr` (cmd 0x11) during REQ
  - required: `overrun`=1, `cmd_code` still the first command, handshake completes normally
- Reset mid-REL:
  - assert `reset_n`=0 while `cmd_ack`=1
  - required: all outputs 0 asynchronously
  - the next `host_wr` enters DRAIN and completes once `cmd_ack` falls
- Back-to-back:
  - `host_wr` in the `done` cycle
  - required: accepted, `busy` high the next cycle, both commands get a `done`
